// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared types and constants for the stopwatch display slice.
//   - bcd_t      : one BCD digit
//   - dig_idx_t  : scan slot index (DIG_MIN=5 .. DIG_MILLI=0)
//   - digits_t   : the six buffered digits
//   - SEG_*      : seven-segment glyphs {g,f,e,d,c,b,a}, active-high
//   - LIMIT_MIN  : minutes value at which the optional limit blink engages
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [2:0] dig_idx_t;

  localparam dig_idx_t DIG_MIN   = 3'd5;
  localparam dig_idx_t DIG_SEG2  = 3'd4;
  localparam dig_idx_t DIG_SEG1  = 3'd3;
  localparam dig_idx_t DIG_DECI  = 3'd2;
  localparam dig_idx_t DIG_CENTI = 3'd1;
  localparam dig_idx_t DIG_MILLI = 3'd0;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam bcd_t LIMIT_MIN = 4'd2;

  typedef struct packed {
    bcd_t min;
    bcd_t seg2;
    bcd_t seg1;
    bcd_t deci;
    bcd_t centi;
    bcd_t milli;
  } digits_t;

endpackage

// File: rtl/stopwatch_display_bcd_to_7seg.sv
// bcd_to_7seg
//   Purely combinational BCD to seven-segment glyph decoder, active-high.
//   Values 10..15 are not BCD and show a dash (segment g only).
// Ports:
//   bcd   in  4  digit value
//   glyph out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module bcd_to_7seg
  import stopwatch_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] glyph
);

  // Glyph lookup
  always_comb begin
    glyph = SEG_DASH;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display
//   Drives a 6-digit multiplexed seven-segment display from the stopwatch
//   counter's BCD digits. Adds a lap/hold snapshot buffer, leading-zero
//   blanking of the minutes/tens-of-seconds digits and fixed decimal points.
//   All pin outputs are registered.
// Optional feature (macro LIMIT_BLINK_EN):
//   When defined, the whole display blinks (all anodes off during the off
//   half, period 2*BLINK_DIV scan slots) while the buffered minutes digit
//   equals LIMIT_MIN. When undefined the display is always steady.
// Ports:
//   clk        in  1  system clock, rising edge
//   reset      in  1  asynchronous active-low reset
//   min..milli in  4  live BCD digits from the counter
//   lap_toggle in  1  pulse; toggles hold mode
//   frozen     out 1  1 = held snapshot displayed
//   seg        out 7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp         out 1  decimal point of selected digit, same polarity as seg
//   an         out 6  one-hot digit select, an[5]=min .. an[0]=milli
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter int BLINK_DIV      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  bcd_t       min,
  input  bcd_t       seg2,
  input  bcd_t       seg1,
  input  bcd_t       deci,
  input  bcd_t       centi,
  input  bcd_t       milli,
  input  logic       lap_toggle,
  output logic       frozen,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // XOR masks that turn active-high internal values into pin polarity;
  // they are also the "all unlit / all deselected" reset patterns.
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [5:0] AN_OFF  = {6{AN_ACTIVE_LOW}};

  logic [PW-1:0] presc_r;
  logic          scan_tick_s;
  dig_idx_t      idx_r;
  logic          frozen_r;
  digits_t       buf_r;
  digits_t       live_s;

  bcd_t          digit_s;
  logic          blank_s;
  logic          dp_on_s;
  logic [5:0]    an_on_s;
  logic [6:0]    glyph_s;
  logic [6:0]    seg_on_s;
  logic [5:0]    an_vis_s;
  logic          blink_off_s;

  logic [6:0]    seg_r;
  logic          dp_r;
  logic [5:0]    an_r;

  assign live_s      = '{min: min, seg2: seg2, seg1: seg1,
                         deci: deci, centi: centi, milli: milli};
  assign scan_tick_s = (presc_r == PW'(CLK_DIV - 1));

  // Scan prescaler: counts 0..CLK_DIV-1 and wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= '0;
    end else if (scan_tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Digit index: steps 5 -> 4 -> ... -> 0 -> 5 once per scan slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r <= DIG_MILLI;
    end else if (scan_tick_s) begin
      idx_r <= (idx_r == DIG_MILLI) ? DIG_MIN : (idx_r - 3'd1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Hold mode and snapshot buffer. The buffer decision uses the frozen
  // value before the edge, so a freezing pulse still captures that edge's
  // inputs and an unfreezing pulse resumes loading one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frozen_r <= 1'b0;
      buf_r    <= '0;
    end else begin
      frozen_r <= frozen_r ^ lap_toggle;
      if (!frozen_r) begin
        buf_r <= live_s;
      end else begin
        buf_r <= buf_r;
      end
    end
  end

`ifdef LIMIT_BLINK_EN
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_r;
  logic          blink_off_r;

  // Limit blink: half-period counter of scan slots, parked in the on phase
  // whenever the buffered minutes are not at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else if (buf_r.min != LIMIT_MIN) begin
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else if (scan_tick_s) begin
      if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
        blink_cnt_r <= '0;
        blink_off_r <= ~blink_off_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
        blink_off_r <= blink_off_r;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_off_r <= blink_off_r;
    end
  end

  assign blink_off_s = blink_off_r;
`else
  assign blink_off_s = 1'b0;
`endif

  // Digit select, blanking and decimal point for the current slot
  always_comb begin
    digit_s = 4'd0;
    blank_s = 1'b1;
    dp_on_s = 1'b0;
    an_on_s = 6'b000000;
    case (idx_r)
      DIG_MIN: begin
        digit_s = buf_r.min;
        blank_s = (buf_r.min == 4'd0);
        dp_on_s = (buf_r.min != 4'd0);
        an_on_s = 6'b100000;
      end
      DIG_SEG2: begin
        digit_s = buf_r.seg2;
        blank_s = (buf_r.min == 4'd0) && (buf_r.seg2 == 4'd0);
        an_on_s = 6'b010000;
      end
      DIG_SEG1: begin
        digit_s = buf_r.seg1;
        blank_s = 1'b0;
        dp_on_s = 1'b1;
        an_on_s = 6'b001000;
      end
      DIG_DECI: begin
        digit_s = buf_r.deci;
        blank_s = 1'b0;
        an_on_s = 6'b000100;
      end
      DIG_CENTI: begin
        digit_s = buf_r.centi;
        blank_s = 1'b0;
        an_on_s = 6'b000010;
      end
      DIG_MILLI: begin
        digit_s = buf_r.milli;
        blank_s = 1'b0;
        an_on_s = 6'b000001;
      end
      default: begin
        digit_s = 4'd0;
        blank_s = 1'b1;
        dp_on_s = 1'b0;
        an_on_s = 6'b000000;
      end
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd   (digit_s),
    .glyph (glyph_s)
  );

  // Apply blanking and blink gating to the decoded slot
  always_comb begin
    seg_on_s = 7'h00;
    an_vis_s = 6'b000000;
    if (blank_s) begin
      seg_on_s = 7'h00;
    end else begin
      seg_on_s = glyph_s;
    end
    if (blink_off_s) begin
      an_vis_s = 6'b000000;
    end else begin
      an_vis_s = an_on_s;
    end
  end

  // Pin output register with polarity conversion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_r <= SEG_OFF;
      dp_r  <= DP_OFF;
      an_r  <= AN_OFF;
    end else begin
      seg_r <= seg_on_s ^ SEG_OFF;
      dp_r  <= dp_on_s ^ DP_OFF;
      an_r  <= an_vis_s ^ AN_OFF;
    end
  end

  assign frozen = frozen_r;
  assign seg    = seg_r;
  assign dp     = dp_r;
  assign an     = an_r;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display
//   Directed, table-driven bench for stopwatch_display with CLK_DIV=4,
//   active-low segments and anodes, BLINK_DIV=2.
//   Slot timing after reset release (cyc = edges since release):
//   outputs for scan slot s are visible for cyc in [4s+1, 4s+4], and the
//   slot index is (6 - s%6) % 6. Samples are taken on the falling edge.
module tb_stopwatch_display;
  import stopwatch_pkg::*;

  logic       clk;
  logic       reset;
  bcd_t       min, seg2, seg1, deci, centi, milli;
  logic       lap_toggle;
  logic       frozen;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int checks;
  int errors;
  int cyc;

  stopwatch_display #(
    .CLK_DIV        (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1),
    .BLINK_DIV      (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .min        (min),
    .seg2       (seg2),
    .seg1       (seg1),
    .deci       (deci),
    .centi      (centi),
    .milli      (milli),
    .lap_toggle (lap_toggle),
    .frozen     (frozen),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [5:0][3:0] d;   // inputs, [5]=min .. [0]=milli
    logic [5:0][6:0] s;   // expected seg pins per slot index
    logic [5:0]      p;   // expected dp pins per slot index
  } vec_t;

  vec_t vecs[6];

  function automatic int slot_idx(input int c);
    return (6 - (c / 4) % 6) % 6;
  endfunction

  function automatic logic [5:0] an_exp(input int idx);
    logic [5:0] one;
    one = 6'b000001;
    return 6'h3F ^ (one << idx);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [5:0][3:0] d);
    min = d[5]; seg2 = d[4]; seg1 = d[3]; deci = d[2]; centi = d[1]; milli = d[0];
  endtask

  // Wait for the falling edge where cyc % 4 == m
  task automatic wait_mod(input int m, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 16) begin
      @(negedge clk);
      n++;
      ok = (cyc % 4 == m);
    end
    if (!ok) chk("wait_mod_timeout", 32'd1, 32'd0);
  endtask

  // Wait for the mid-slot sample point of slot index idx, then compare
  task automatic check_slot(input string name, input int idx,
                            input logic [6:0] es, input logic ep, input logic [5:0] ea);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      @(negedge clk);
      n++;
      ok = (cyc % 4 == 3) && (slot_idx(cyc) == idx);
    end
    if (!ok) begin
      chk({name, "_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({name, "_seg"}, 32'(seg), 32'(es));
      chk({name, "_dp"},  32'(dp),  32'(ep));
      chk({name, "_an"},  32'(an),  32'(ea));
    end
  endtask

  logic [5:0][6:0] b_glyph;
  bit              ok;
  int              idx;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{d: {4'd0, 4'd0, 4'd5, 4'd1, 4'd2, 4'd3},
                s: {7'h7F, 7'h7F, 7'h12, 7'h79, 7'h24, 7'h30}, p: 6'b110111};
    vecs[1] = '{d: {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6},
                s: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, p: 6'b010111};
    vecs[2] = '{d: {4'd0, 4'd0, 4'd0, 4'hC, 4'd0, 4'd0},
                s: {7'h7F, 7'h7F, 7'h40, 7'h3F, 7'h40, 7'h40}, p: 6'b110111};
    vecs[3] = '{d: {4'd0, 4'd3, 4'd0, 4'd7, 4'd8, 4'd9},
                s: {7'h7F, 7'h30, 7'h40, 7'h78, 7'h00, 7'h10}, p: 6'b110111};
    vecs[4] = '{d: {4'd9, 4'd0, 4'd9, 4'd9, 4'd9, 4'd9},
                s: {7'h10, 7'h40, 7'h10, 7'h10, 7'h10, 7'h10}, p: 6'b010111};
    vecs[5] = '{d: {4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
                s: {7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, p: 6'b010111};

    // Snapshot B = 4,5,6,7,8,9 as displayed (min non-zero, so nothing blanked)
    b_glyph = {7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    reset      = 1'b1;
    lap_toggle = 1'b0;
    set_in({4'd0, 4'd0, 4'd5, 4'd1, 4'd2, 4'd3});
    #2 reset = 1'b0;
    #1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'h3F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_frozen", 32'(frozen), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("first_slot_an", 32'(an), 32'h3E);

    // Static display patterns
    for (int k = 0; k < 6; k++) begin
      set_in(vecs[k].d);
      repeat (2) @(negedge clk);
      for (int i = 5; i >= 0; i--) begin
        check_slot($sformatf("vec%0d_slot%0d", k, i), i, vecs[k].s[i], vecs[k].p[i], an_exp(i));
      end
    end

    // Freeze: snapshot taken on the pulse edge, held for 3 scans
    set_in({4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7});
    repeat (2) @(negedge clk);
    set_in({4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9});
    lap_toggle = 1'b1;
    @(negedge clk);
    lap_toggle = 1'b0;
    set_in({4'd3, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1});
    chk("freeze_frozen", 32'(frozen), 32'd1);
    for (int sc = 0; sc < 3; sc++) begin
      for (int i = 5; i >= 0; i--) begin
        check_slot($sformatf("hold%0d_slot%0d", sc, i), i, b_glyph[i],
                   (i == 5 || i == 3) ? 1'b0 : 1'b1, an_exp(i));
      end
      set_in({4'(5 + sc), 4'd5, 4'd5, 4'd0, 4'd1, 4'd5});
    end

    // Unfreeze: buffer goes live one edge after the pulse edge
    wait_mod(1, ok);
    idx = slot_idx(cyc);
    lap_toggle = 1'b1;
    set_in({4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3});
    @(negedge clk);
    lap_toggle = 1'b0;
    chk("unfreeze_frozen", 32'(frozen), 32'd0);
    chk("unfreeze_seg_e1", 32'(seg), 32'(b_glyph[idx]));
    @(negedge clk);
    chk("unfreeze_seg_e2", 32'(seg), 32'(b_glyph[idx]));
    @(negedge clk);
    chk("unfreeze_seg_live", 32'(seg), 32'h30);

    // lap_toggle held high toggles every cycle
    lap_toggle = 1'b1;
    @(negedge clk);
    chk("held_lap_1", 32'(frozen), 32'd1);
    @(negedge clk);
    lap_toggle = 1'b0;
    chk("held_lap_2", 32'(frozen), 32'd0);
    @(negedge clk);
    chk("held_lap_3", 32'(frozen), 32'd0);

    // Mid-scan reset with lap_toggle asserted
    repeat (5) @(negedge clk);
    reset      = 1'b0;
    lap_toggle = 1'b1;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_an", 32'(an), 32'h3F);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_over_lap", 32'(frozen), 32'd0);
    chk("mid_rst_an_hold", 32'(an), 32'h3F);
    lap_toggle = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    chk("mid_rst_first_an", 32'(an), 32'h3E);
    chk("mid_rst_first_dp", 32'(dp), 32'd1);
    check_slot("after_rst_slot3", 3, 7'h30, 1'b0, an_exp(3));

`ifdef LIMIT_BLINK_EN
    // min=2: two slots on, two slots off
    wait_mod(1, ok);
    set_in({4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3});
    repeat (2) @(negedge clk);
    chk("blink_k0", 32'(an), 32'(an_exp(slot_idx(cyc))));
    for (int k = 1; k <= 8; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("blink_k%0d", k), 32'(an),
          ((k % 4) < 2) ? 32'(an_exp(slot_idx(cyc))) : 32'h3F);
    end
    // min=1: steady
    set_in({4'd1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3});
    repeat (4) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("noblink_k%0d", k), 32'(an), 32'(an_exp(slot_idx(cyc))));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream of the stopwatch counter: consumes its six BCD digits (min, seg2, seg1, deci, centi, milli) and drives a 6-digit multiplexed seven-segment display.
- Adds a lap/hold snapshot, leading-zero blanking and fixed decimal points.
- Registered outputs go straight to the board pins.

Parameters:
- CLK_DIV, 50000: clk cycles per digit scan slot; legal range is ≥2.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp driven low to light; 0 = high to light.
- AN_ACTIVE_LOW, 1: 1 = an bit low selects a digit; 0 = high selects.
- BLINK_DIV, 64: scan slots per blink half-period; used only with LIMIT_BLINK_EN.

Ports:
- clk  in  1  single system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset: asserts immediately while low, releases synchronously to clk.
- min  in  4  minutes digit (BCD).
- seg2  in  4  tens-of-seconds digit.
- seg1  in  4  seconds digit.
- deci  in  4  tenths digit.
- centi  in  4  hundredths digit.
- milli  in  4  thousandths digit.
- lap_toggle  in  1  one-cycle pulse; toggles hold mode.
- frozen  out  1  1 = display shows the held snapshot.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point of the selected digit.
- an  out  6  digit select, one-hot; an[5]=min … an[0]=milli.

Behaviour:
- Reset (reset low):
  - prescaler=0, idx=0, frozen=0, display buffer all 0.
  - seg and dp all unlit; an all deselected.
  - Reset overrides lap_toggle on the same edge.
- Buffer:
  - When frozen=0, the buffer loads all six inputs every clk, so latency from input to buffer is 1 cycle.
  - When frozen=1, the buffer holds its value.
- lap_toggle=1 toggles frozen.
  - Freezing (0→1): the buffer captures the input values present on that same edge.
  - Unfreezing: live loading resumes on the next edge.
  - lap_toggle held high toggles frozen every cycle; no edge detection is done here.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - scan_tick=1 when the count is CLK_DIV-1.
  - On scan_tick, idx advances 5→4→…→0→5. The first slot after reset is idx 0.
- Output register:
  - seg/dp/an are registered from the current idx and buffer every cycle, so they change 1 clk after idx changes.
  - an is exactly one-hot selected for idx; all others are deselected.
- Decode:
  - Values 0–9 use the standard 7-segment glyphs.
  - Values 10–15 show segment g only ("-").
- Blanking:
  - min digit blanked (seg unlit) when min==0.
  - seg2 digit blanked when min==0 and seg2==0.
  - Other digits are never blanked.
- dp lit on the min digit (only when min≠0) and on the seg1 digit; unlit on all others.
- A reset pulse mid-scan returns to idx 0 with unlit outputs on the next edge after release.

Optional Feature:
- Macro name: LIMIT_BLINK_EN.
- Defined:
  - Adds a blink counter of scan slots, period 2*BLINK_DIV.
  - While the buffered min==2 (counter limit reached), all an bits are deselected during the off half.
  - Blink phase resets to on whenever min≠2 and on reset.
- Undefined: no blink counter; the display is always steady.

Decomposition:
- Package stopwatch_pkg holds:
  - typedef bcd_t (4-bit).
  - Digit index constants DIG_MIN..DIG_MILLI (5..0).
  - Glyph constants SEG_0..SEG_9 and SEG_DASH, stored active-high.
  - LIMIT_MIN = 2.
- One sub-module, bcd_to_7seg: purely combinational bcd_t → active-high 7-bit glyph.
- Polarity inversion is done in the top-level output register.

Test Plan (CLK_DIV=4):
- Reset low mid-run, then release: seg=7'h7F, an=6'h3F, dp=1 until the first output register update; after release, an[0] is selected first.
- Inputs 0,0,5,1,2,3: slots show min blank/no dp, seg2 blank, seg1 "5" with dp, then "1","2","3"; an cycles one-hot with a slot length of 4 clk.
- Inputs 1,2,3,4,5,6: all digits shown; dp lit on an[5] and an[3] only.
- With live inputs changing, pulse lap_toggle: frozen=1, and the display keeps the values sampled on the pulse edge for 3 full scans; a second pulse gives frozen=0 and live values one cycle later.
- Drive deci=4'hC: slot an[2] shows seg=g only.
- With LIMIT_BLINK_EN and BLINK_DIV=2, set min=2: an all deselected for 2 slots, active for 2 slots, repeating; with min=1 there is no blink.
